// File: rtl/chip_link_tx_arb.sv
// Link transmit scheduler: round-robin packet grant, MSW-first serialisation onto a
// four-phase valid/ready link with even parity and bounded per-word retransmission.
module chip_link_tx_arb #(
  parameter int FW             = 59,
  parameter int CONNECT        = 2,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int NREQ           = 4,
  parameter int MAX_RETRY      = 3,
  localparam int PW   = FW + $clog2(CONNECT),
  localparam int CW   = CHIPDATA_WIDTH,
  localparam int NW   = (PW + CW - 1) / CW,
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int WIW  = (NW > 1) ? $clog2(NW) : 1,
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*PW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [CW-1:0]        send_data_out,
  output logic                 send_data_valid,
  output logic                 send_data_par,
  input  logic                 send_data_ready,
  input  logic                 send_data_err,
  output logic                 busy,
  output logic                 link_fault
);

  // state   | meaning
  // IDLE    | no packet in flight; arbitrate and capture a packet
  // LOAD    | present word[word_idx] with parity, raise valid
  // DRIVE   | hold word until far side acknowledges; classify err
  // RELEASE | wait for ack to drop; resend, drop, advance or finish
  typedef enum logic [1:0] {IDLE, LOAD, DRIVE, RELEASE} state_e;

  state_e              state_q, state_d;
  logic [PTRW-1:0]     rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic [NW*CW-1:0]    pkt_q, pkt_d;
  logic [WIW-1:0]      widx_q, widx_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic                resend_q, resend_d, drop_q, drop_d;
  logic [CW-1:0]       out_q, out_d;
  logic                valid_q, valid_d, par_q, par_d, fault_q, fault_d;
  logic [NREQ-1:0]     rdy_q, rdy_d;

  logic                found;
  logic [PTRW-1:0]     pick;
  logic [PTRW:0]       cand;
  logic [CW-1:0]       cur_word;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTRW+1)'(k);
      if (cand >= (PTRW+1)'(NREQ)) cand = cand - (PTRW+1)'(NREQ);
      if (!found && req_valid[cand[PTRW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PTRW-1:0];
      end
    end
  end

  assign cur_word = pkt_q[(NW - 1 - int'(widx_q)) * CW +: CW];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    pkt_d    = pkt_q;
    widx_d   = widx_q;
    retry_d  = retry_q;
    resend_d = resend_q;
    drop_d   = drop_q;
    out_d    = out_q;
    valid_d  = valid_q;
    par_d    = par_q;
    rdy_d    = '0;
    fault_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d     = pick;
          pkt_d       = (NW*CW)'(req_data[int'(pick) * PW +: PW]);
          rdy_d[pick] = 1'b1;
          widx_d      = '0;
          retry_d     = '0;
          resend_d    = 1'b0;
          drop_d      = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        out_d   = cur_word;
        par_d   = ^cur_word;
        valid_d = 1'b1;
        state_d = DRIVE;
      end
      DRIVE: begin
        if (send_data_ready) begin
          valid_d = 1'b0;
          if (send_data_err) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d  = retry_q + 1'b1;
              resend_d = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!send_data_ready) begin
          if (resend_q) begin
            resend_d = 1'b0;
            state_d  = LOAD;
          end else if (!drop_q && widx_q < WIW'(NW - 1)) begin
            widx_d  = widx_q + 1'b1;
            retry_d = '0;
            state_d = LOAD;
          end else begin
            fault_d  = drop_q;
            drop_d   = 1'b0;
            rr_ptr_d = (grant_q == PTRW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      pkt_q    <= '0;
      widx_q   <= '0;
      retry_q  <= '0;
      resend_q <= 1'b0;
      drop_q   <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      par_q    <= 1'b0;
      rdy_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      pkt_q    <= pkt_d;
      widx_q   <= widx_d;
      retry_q  <= retry_d;
      resend_q <= resend_d;
      drop_q   <= drop_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      par_q    <= par_d;
      rdy_q    <= rdy_d;
      fault_q  <= fault_d;
    end
  end

  assign req_ready       = rdy_q;
  assign send_data_out   = out_q;
  assign send_data_valid = valid_q;
  assign send_data_par   = par_q;
  assign link_fault      = fault_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_chip_link_tx_arb.sv
// Bench for chip_link_tx_arb: far-side responder plus grant/word scoreboards.
module tb_chip_link_tx_arb;
  localparam int NREQ = 4;
  localparam int PW   = 60;
  localparam int NW   = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*PW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [15:0]         send_data_out;
  logic                send_data_valid, send_data_par;
  logic                send_data_ready = 1'b0, send_data_err = 1'b0;
  logic                busy, link_fault;

  int errors = 0;
  int checks = 0;
  int grants_seen = 0;
  int lf_cycles = 0;
  int remaining[NREQ];
  logic [PW-1:0] pkt_tab[NREQ];
  logic [15:0]   exp_w[$];
  int            exp_g[$];

  always #5 clk = ~clk;

  assign req_data = {pkt_tab[3], pkt_tab[2], pkt_tab[1], pkt_tab[0]};

  chip_link_tx_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .send_data_out(send_data_out), .send_data_valid(send_data_valid),
    .send_data_par(send_data_par), .send_data_ready(send_data_ready),
    .send_data_err(send_data_err), .busy(busy), .link_fault(link_fault)
  );

  always @(negedge clk) if (link_fault === 1'b1) lf_cycles++;

  function automatic logic [15:0] word_of(input logic [PW-1:0] p, input int k);
    logic [63:0] ext;
    ext = {4'b0000, p};
    return ext[63 - 16*k -: 16];
  endfunction

  task automatic push_pkt(input int r);
    for (int k = 0; k < NW; k++) exp_w.push_back(word_of(pkt_tab[r], k));
  endtask

  task automatic note_grant();
    int g;
    int eg;
    logic hit;
    g = -1;
    hit = 1'b0;
    grants_seen++;
    checks++;
    if ($countones(req_ready) != 1) begin
      errors++;
      $display("FAIL grant_onehot: req_ready=%b required exactly one bit", req_ready);
    end
    for (int i = 0; i < NREQ; i++)
      if (!hit && req_ready[i]) begin g = i; hit = 1'b1; end
    checks++;
    if (exp_g.size() == 0) begin
      errors++;
      $display("FAIL grant_extra: granted %0d, required no grant", g);
    end else begin
      eg = exp_g.pop_front();
      if (g !== eg) begin
        errors++;
        $display("FAIL grant_order: granted %0d, required %0d", g, eg);
      end
    end
    if (g >= 0 && remaining[g] > 0) begin
      remaining[g]--;
      if (remaining[g] == 0) req_valid[g] = 1'b0;
    end
  endtask

  task automatic wait_word(output logic ok);
    logic [15:0] e;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (req_ready !== '0) note_grant();
      if (send_data_valid === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_valid: valid=%b, required 1 within 100 cycles", send_data_valid);
      return;
    end
    checks++;
    if (exp_w.size() == 0) begin
      errors++;
      $display("FAIL word_extra: got %h, required no word", send_data_out);
    end else begin
      e = exp_w.pop_front();
      if (send_data_out !== e) begin
        errors++;
        $display("FAIL word_data: got %h, required %h", send_data_out, e);
      end
      checks++;
      if (send_data_par !== ^e) begin
        errors++;
        $display("FAIL word_par: got %b, required %b for %h", send_data_par, ^e, e);
      end
    end
  endtask

  task automatic finish_word(input logic err, input int stall, input int hold_hi);
    logic [15:0] d0;
    logic stable;
    logic low;
    d0 = send_data_out;
    stable = 1'b1;
    low = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (send_data_valid !== 1'b1 || send_data_out !== d0) stable = 1'b0;
    end
    if (stall > 0) begin
      checks++;
      if (!stable) begin
        errors++;
        $display("FAIL stall_stable: valid=%b data=%h, required 1 and %h", send_data_valid, send_data_out, d0);
      end
    end
    send_data_ready = 1'b1;
    send_data_err   = err;
    @(negedge clk);
    send_data_err = 1'b0;
    checks++;
    if (send_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_fall: valid=%b one cycle after ready, required 0", send_data_valid);
    end
    if (hold_hi > 0) begin
      repeat (hold_hi) begin
        @(negedge clk);
        if (send_data_valid !== 1'b0) low = 1'b0;
      end
      checks++;
      if (!low) begin
        errors++;
        $display("FAIL ready_high_hold: valid=%b while ready high, required 0", send_data_valid);
      end
    end
    send_data_ready = 1'b0;
  endtask

  task automatic serve(input logic err, input int stall, input int hold_hi);
    logic ok;
    wait_word(ok);
    if (ok) finish_word(err, stall, hold_hi);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (send_data_out !== 16'h0 || send_data_valid !== 1'b0 || send_data_par !== 1'b0 ||
        req_ready !== '0 || busy !== 1'b0 || link_fault !== 1'b0) begin
      errors++;
      $display("FAIL %s: out=%h valid=%b par=%b rdy=%b busy=%b fault=%b, required all zero",
               tag, send_data_out, send_data_valid, send_data_par, req_ready, busy, link_fault);
    end
  endtask

  task automatic apply_reset();
    req_valid = '0;
    send_data_ready = 1'b0;
    send_data_err = 1'b0;
    for (int i = 0; i < NREQ; i++) remaining[i] = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_values");
    apply_reset();
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_single();
    int g0;
    int lf0;
    g0 = grants_seen;
    lf0 = lf_cycles;
    remaining[0] = 1;
    exp_g.push_back(0);
    push_pkt(0);
    req_valid[0] = 1'b1;
    repeat (NW) serve(1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_end: busy=%b, required 0", busy);
    end
    checks++;
    if (grants_seen - g0 != 1) begin
      errors++;
      $display("FAIL single_grant_count: %0d pulses, required 1", grants_seen - g0);
    end
    checks++;
    if (lf_cycles != lf0) begin
      errors++;
      $display("FAIL single_no_fault: fault cycles %0d, required 0", lf_cycles - lf0);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < NREQ; i++) remaining[i] = 2;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NREQ; i++) begin
        exp_g.push_back(i);
        push_pkt(i);
      end
    req_valid = 4'b1111;
    repeat (8 * NW) serve(1'b0, 0, 0);
    remaining[1] = 2;
    remaining[3] = 2;
    for (int p = 0; p < 2; p++) begin
      exp_g.push_back(1); push_pkt(1);
      exp_g.push_back(3); push_pkt(3);
    end
    req_valid = 4'b1010;
    repeat (4 * NW) serve(1'b0, 0, 0);
  endtask

  task automatic test_parity_error();
    int lf0;
    lf0 = lf_cycles;
    remaining[0] = 1;
    exp_g.push_back(0);
    exp_w.push_back(word_of(pkt_tab[0], 0));
    exp_w.push_back(word_of(pkt_tab[0], 1));
    exp_w.push_back(word_of(pkt_tab[0], 2));
    exp_w.push_back(word_of(pkt_tab[0], 2));
    exp_w.push_back(word_of(pkt_tab[0], 3));
    req_valid[0] = 1'b1;
    serve(1'b0, 0, 0);
    serve(1'b0, 0, 0);
    serve(1'b1, 0, 0);
    serve(1'b0, 0, 0);
    serve(1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (lf_cycles != lf0) begin
      errors++;
      $display("FAIL parity_no_fault: fault cycles %0d, required 0", lf_cycles - lf0);
    end
  endtask

  task automatic test_retry_exhaust();
    int lf0;
    lf0 = lf_cycles;
    remaining[1] = 2;
    exp_g.push_back(1);
    exp_g.push_back(1);
    exp_w.push_back(word_of(pkt_tab[1], 0));
    repeat (4) exp_w.push_back(word_of(pkt_tab[1], 1));
    push_pkt(1);
    req_valid[1] = 1'b1;
    serve(1'b0, 0, 0);
    repeat (4) serve(1'b1, 0, 0);
    repeat (NW) serve(1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (lf_cycles - lf0 != 1) begin
      errors++;
      $display("FAIL retry_fault_pulse: fault cycles %0d, required 1", lf_cycles - lf0);
    end
  endtask

  task automatic test_stall();
    remaining[2] = 1;
    exp_g.push_back(2);
    push_pkt(2);
    req_valid[2] = 1'b1;
    serve(1'b0, 50, 20);
    repeat (NW - 1) serve(1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    logic ok;
    remaining[0] = 1;
    remaining[3] = 1;
    exp_g.push_back(3);
    push_pkt(3);
    req_valid = 4'b1001;
    serve(1'b0, 0, 0);
    serve(1'b0, 0, 0);
    wait_word(ok);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_packet");
    exp_w.delete();
    remaining[0] = 1;
    remaining[3] = 1;
    req_valid = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    exp_g.push_back(0); push_pkt(0);
    exp_g.push_back(3); push_pkt(3);
    repeat (2 * NW) serve(1'b0, 0, 0);
  endtask

  initial begin
    pkt_tab[0] = 60'h123456789ABCDEF;
    pkt_tab[1] = 60'hFEDCBA987654321;
    pkt_tab[2] = 60'hA5A5A5A0F0FF0F0;
    pkt_tab[3] = 60'h0F1223344556677;
    for (int i = 0; i < NREQ; i++) remaining[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_parity_error();
    test_retry_exhaust();
    test_stall();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_w.size() != 0 || exp_g.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d words %0d grants left, required 0 and 0",
               exp_w.size(), exp_g.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
